keypad_move_conditioner: RTL and testbench
==========================================

// Module: keypad_move_conditioner
// PURPOSE
//  Upstream of the maze/player FSM. Converts raw, bouncy keypad buttons into a clean one-hot move command.
//  The player FSM samples keypad[3:0] only while idle between moves, so a command is held until acked.
//  While a button stays held, the command auto-repeats at a fixed rate. Bits 7:4 pass through debounced.
// PARAMETERS
//  DB_CYCLES   20'd50000    debounce stable time in clk cycles (1 ms @ 50 MHz)
//  RPT_CYCLES  24'd5000000  hold-to-repeat interval in clk cycles (100 ms @ 50 MHz)
// PORTS
//  clk         in   1   system clock, single clock domain
//  rst         in   1   asynchronous, active-high reset
//  keypad_raw  in   8   raw buttons, async, active-high; [0]=left [1]=right [2]=down [3]=up [7:4]=aux
//  ack         in   1   one-cycle pulse from player FSM: current move command consumed
//  keypad      out  8   [3:0] one-hot move command (or 0); [7:4] debounced aux levels
//  move_valid  out  1   high while keypad[3:0] holds a pending command (== |keypad[3:0])
// BEHAVIOUR
//  Reset (async, rst=1): sync FFs, clean, db_cnt, rpt_cnt, dir -> 0; state -> S_IDLE.
//   keypad=8'h00, move_valid=0, immediately on rst assertion.
//  Sync: 2-FF synchroniser per bit -> sync[7:0]. Raw-to-sync latency is 2 cycles.
//  Debounce (shared, vector-wide):
//   - sync != sync_d (previous cycle) -> db_cnt <= 0.
//   - otherwise, if db_cnt == DB_CYCLES-1 -> clean <= sync; db_cnt holds (saturates).
//   - otherwise db_cnt++.
//   - Result: clean updates DB_CYCLES cycles after the last sync change. Any glitch restarts the count.
//  Priority encode: pick = lowest set bit of clean[3:0] (left>right>down>up), one-hot 4b; 0 if none.
//  FSM (registered state; outputs decoded from state+dir):
//   S_IDLE:    keypad[3:0]=0. If pick!=0: dir<=pick, go S_PRESENT.
//   S_PRESENT: keypad[3:0]=dir, move_valid=1.
//              On ack: go S_WAIT, rpt_cnt<=RPT_CYCLES-1.
//              Key release before ack does NOT cancel the command (press never lost).
//   S_WAIT:    keypad[3:0]=0.
//              If (clean[3:0] & dir)==0 (released, or changed to another key): go S_IDLE, same cycle decision.
//              Else if rpt_cnt==0: dir<=pick, go S_PRESENT. Else rpt_cnt--.
//  ack outside S_PRESENT: ignored.
//  New key pressed while S_PRESENT: ignored; dir stays latched until ack.
//  Simultaneous multi-key: priority encode only, never multi-hot on [3:0].
//  keypad[7:4] = clean[7:4] in all states; no latching, no repeat.
//  Counter widths: db_cnt 20 b, rpt_cnt 24 b, no wrap (db saturates, rpt stops at 0).
//  rst asserted mid-command: the pending command is dropped; after release, a still-held key re-enters
//   S_PRESENT once the debounce completes.
// STRUCTURE
//  Shared package: S_IDLE/S_PRESENT/S_WAIT localparams (2-bit encoding); KEY_LEFT/RIGHT/DOWN/UP bit indices
//   (0..3), also used by the player FSM.
//  Sub-module: keypad_debounce (sync + shared-counter debounce, parameter DB_CYCLES, 8-bit vector).
//   FSM and repeat logic stay in the top module.
// TESTING (sim with DB_CYCLES=4, RPT_CYCLES=8)
//  1. Bounce: keypad_raw[1] toggles 3x, 1 cycle apart, then stays 1.
//     -> keypad=8'h02 exactly 2+4(+1 state) cycles after last edge, no earlier; move_valid=1.
//  2. Tap + late ack: raw[0] high 10 cycles, released, ack 20 cycles later.
//     -> keypad stays 8'h01 until ack; 8'h00 after; FSM returns to S_IDLE.
//  3. Hold/repeat: raw[3] held, ack pulsed one cycle after each move_valid rise.
//     -> move_valid re-rises every 9-10 cycles, keypad=8'h08 each time.
//  4. Priority: raw=8'h0C (down+up) simultaneously -> keypad[3:0]=4'h4 only.
//     Switch to 8'h08 during S_WAIT -> S_IDLE, then 4'h8 after debounce.
//  5. Aux + reset: raw=8'h31; assert rst mid-S_PRESENT -> keypad=8'h00 asynchronously.
//     Release rst -> keypad=8'h31 after debounce.
//  6. Stray ack while in S_IDLE/S_WAIT -> no state change, keypad unchanged.

Source files
------------

// File: rtl/keypad_move_conditioner_pkg.sv
// Shared keypad definitions: move-command FSM states, key bit positions and widths.
// The player FSM imports the KEY_* indices to decode keypad[3:0].
package keypad_move_conditioner_pkg;

  localparam int unsigned KEYS_W = 8;
  localparam int unsigned MOVE_W = 4;
  localparam int unsigned DB_W   = 20;
  localparam int unsigned RPT_W  = 24;

  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_RIGHT = 1;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_UP    = 3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1,
    S_WAIT    = 2'd2
  } state_t;

  // Lowest set bit wins, so left > right > down > up.
  function automatic logic [MOVE_W-1:0] pick_lowest(input logic [MOVE_W-1:0] v);
    return v & (~v + MOVE_W'(1));
  endfunction

endpackage

// File: rtl/keypad_move_conditioner_if.sv
// Keypad-to-player link: raw buttons and ack in, conditioned move command out.
interface keypad_move_conditioner_if;
  import keypad_move_conditioner_pkg::*;

  logic [KEYS_W-1:0] keypad_raw;
  logic              ack;
  logic [KEYS_W-1:0] keypad;
  logic              move_valid;

  modport master (output keypad_raw, output ack, input keypad, input move_valid);
  modport slave  (input keypad_raw, input ack, output keypad, output move_valid);

endinterface

// File: rtl/keypad_move_conditioner_debounce.sv
// 2-FF synchroniser plus one shared debounce counter for the whole button vector.
// Any change on any bit restarts the count; clean follows sync once it has been still long enough.
module keypad_debounce
  import keypad_move_conditioner_pkg::*;
#(
  parameter logic [DB_W-1:0] DB_CYCLES = 20'd50000,
  parameter int unsigned     WIDTH     = KEYS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean
);

  localparam logic [DB_W-1:0] DB_MAX = DB_CYCLES - DB_W'(1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] sync_d;
  logic [DB_W-1:0]  db_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
      sync_d    <= '0;
      db_cnt    <= '0;
      clean     <= '0;
    end else begin
      sync_meta <= raw;
      sync      <= sync_meta;
      sync_d    <= sync;
      if (sync != sync_d) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        clean <= sync;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/keypad_move_conditioner.sv
// Turns debounced keypad buttons into a one-hot move command held until acked,
// with hold-to-repeat; aux bits [7:4] pass through debounced.
module keypad_move_conditioner
  import keypad_move_conditioner_pkg::*;
#(
  parameter logic [DB_W-1:0]  DB_CYCLES  = 20'd50000,
  parameter logic [RPT_W-1:0] RPT_CYCLES = 24'd5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  keypad_move_conditioner_if.slave  kp
);

  logic [KEYS_W-1:0] clean;
  logic [MOVE_W-1:0] pick;
  logic [MOVE_W-1:0] dir;
  logic [MOVE_W-1:0] cmd;
  logic              valid;
  logic [RPT_W-1:0]  rpt_cnt;
  state_t            state;

  keypad_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .WIDTH     (KEYS_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   (kp.keypad_raw),
    .clean (clean)
  );

  assign pick = pick_lowest(clean[MOVE_W-1:0]);

  // Command FSM; cmd/valid are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      dir     <= '0;
      cmd     <= '0;
      valid   <= 1'b0;
      rpt_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick != '0) begin
            dir   <= pick;
            cmd   <= pick;
            valid <= 1'b1;
            state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          // Releasing the key here does not cancel: the press is kept until consumed.
          if (kp.ack) begin
            cmd     <= '0;
            valid   <= 1'b0;
            rpt_cnt <= RPT_CYCLES - RPT_W'(1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if ((clean[MOVE_W-1:0] & dir) == '0) begin
            state <= S_IDLE;
          end else if (rpt_cnt == '0) begin
            dir   <= pick;
            cmd   <= pick;
            valid <= 1'b1;
            state <= S_PRESENT;
          end else begin
            rpt_cnt <= rpt_cnt - RPT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign kp.keypad     = {clean[KEYS_W-1:MOVE_W], cmd};
  assign kp.move_valid = valid;

endmodule

// File: tb/tb_keypad_move_conditioner.sv
// Directed scenarios followed by random bouncy buttons and acks, every cycle checked
// against a history-based model of debounce, priority, hold-until-ack and repeat.
module tb_keypad_move_conditioner;

  localparam int DB  = 4;
  localparam int RPT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  keypad_move_conditioner_if kif ();

  keypad_move_conditioner #(
    .DB_CYCLES  (20'(DB)),
    .RPT_CYCLES (24'(RPT))
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: raw sample history, debounced value, pending command, repeat bookkeeping.
  logic [7:0] hist[$];
  logic [7:0] m_clean;
  logic [3:0] m_cmd;
  logic [3:0] m_dir;
  bit         m_waiting;
  int         cyc;
  int         m_ack_cyc;

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < DB + 3; i++) hist.push_back(8'h00);
    m_clean   = 8'h00;
    m_cmd     = 4'h0;
    m_dir     = 4'h0;
    m_waiting = 1'b0;
    cyc       = 0;
    m_ack_cyc = 0;
  endfunction

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 4'(1 << i);
    return 4'h0;
  endfunction

  function automatic void model_edge(input logic [7:0] raw, input logic ack);
    logic [3:0] held;
    logic [3:0] pick;
    bit         stable;
    held = m_clean[3:0];
    pick = lowest(held);
    cyc++;
    if (m_cmd != 4'h0) begin
      if (ack) begin
        m_cmd     = 4'h0;
        m_waiting = 1'b1;
        m_ack_cyc = cyc;
      end
    end else if (m_waiting) begin
      if ((held & m_dir) == 4'h0) begin
        m_waiting = 1'b0;
      end else if (cyc - m_ack_cyc >= RPT) begin
        m_waiting = 1'b0;
        m_cmd     = pick;
        m_dir     = pick;
      end
    end else if (pick != 4'h0) begin
      m_cmd = pick;
      m_dir = pick;
    end
    // Debounced value = input seen two samples ago, once DB+1 consecutive samples agree.
    hist.push_back(raw);
    void'(hist.pop_front());
    stable = 1'b1;
    for (int i = 0; i <= DB; i++) if (hist[i] != hist[DB]) stable = 1'b0;
    if (stable) m_clean = hist[DB];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [7:0] raw, input logic ack);
    kif.keypad_raw = raw;
    kif.ack        = ack;
    @(posedge clk);
    model_edge(raw, ack);
    @(negedge clk);
    check("keypad", 32'(kif.keypad), 32'({m_clean[7:4], m_cmd}));
    check("move_valid", 32'(kif.move_valid), 32'(|m_cmd));
  endtask

  task automatic wait_valid(input string tag, input logic [7:0] raw, input int budget,
                            output int n);
    n = 0;
    while (kif.move_valid !== 1'b1 && n < budget) begin
      tick(raw, 1'b0);
      n++;
    end
    check(tag, 32'(kif.move_valid), 32'(1));
  endtask

  initial begin
    int n;
    logic [7:0] r;
    int len;

    kif.keypad_raw = 8'h00;
    kif.ack        = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_keypad", 32'(kif.keypad), 32'h00);
    check("reset_move_valid", 32'(kif.move_valid), 32'h0);
    rst = 1'b0;
    model_reset();
    repeat (5) tick(8'h00, 1'b0);

    // Bounce on right, then held: command appears 2 sync + DB debounce + 1 state cycles later.
    tick(8'h02, 1'b0);
    tick(8'h00, 1'b0);
    tick(8'h02, 1'b0);
    wait_valid("bounce_valid", 8'h02, 20, n);
    check("bounce_latency", 32'(n), 32'(DB + 3));
    check("bounce_cmd", 32'(kif.keypad), 32'h02);
    repeat (5) tick(8'h02, 1'b0);
    tick(8'h02, 1'b1);
    repeat (15) tick(8'h00, 1'b0);

    // Short tap, ack arrives long after release.
    repeat (10) tick(8'h01, 1'b0);
    repeat (20) tick(8'h00, 1'b0);
    check("tap_held", 32'(kif.keypad), 32'h01);
    tick(8'h00, 1'b1);
    check("tap_acked", 32'(kif.keypad), 32'h00);
    repeat (10) tick(8'h00, 1'b0);
    check("tap_idle", 32'(kif.move_valid), 32'h0);

    // Hold up with prompt acks: repeats every RPT+1 cycles.
    wait_valid("hold_first", 8'h08, 20, n);
    for (int k = 0; k < 4; k++) begin
      tick(8'h08, 1'b1);
      wait_valid("hold_rpt", 8'h08, 20, n);
      check("hold_period", 32'(n + 1), 32'(RPT + 1));
      check("hold_cmd", 32'(kif.keypad), 32'h08);
    end
    tick(8'h08, 1'b1);
    repeat (15) tick(8'h00, 1'b0);

    // Down+up together: down wins; switch to up alone during the repeat wait.
    wait_valid("prio_valid", 8'h0C, 20, n);
    check("prio_cmd", 32'(kif.keypad[3:0]), 32'h4);
    tick(8'h0C, 1'b1);
    wait_valid("prio_switch", 8'h08, 30, n);
    check("prio_switch_cmd", 32'(kif.keypad), 32'h08);
    tick(8'h08, 1'b1);
    repeat (15) tick(8'h00, 1'b0);

    // Aux bits with left, async reset while the command is pending.
    wait_valid("aux_valid", 8'h31, 20, n);
    check("aux_cmd", 32'(kif.keypad), 32'h31);
    #1 rst = 1'b1;
    #1;
    check("rst_async_keypad", 32'(kif.keypad), 32'h00);
    check("rst_async_valid", 32'(kif.move_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_valid("aux_after_rst", 8'h31, 20, n);
    check("aux_after_rst_cmd", 32'(kif.keypad), 32'h31);
    tick(8'h31, 1'b1);
    repeat (15) tick(8'h00, 1'b0);

    // Stray acks in idle and during the repeat wait.
    tick(8'h00, 1'b1);
    check("stray_idle", 32'(kif.keypad), 32'h00);
    wait_valid("stray_valid", 8'h04, 20, n);
    tick(8'h04, 1'b1);
    tick(8'h04, 1'b1);
    tick(8'h04, 1'b1);
    check("stray_wait", 32'(kif.keypad), 32'h00);
    wait_valid("stray_rpt", 8'h04, 20, n);
    check("stray_rpt_cmd", 32'(kif.keypad), 32'h04);
    tick(8'h04, 1'b1);
    repeat (15) tick(8'h00, 1'b0);

    // Random buttons (including 1-cycle glitches) and random acks.
    for (int s = 0; s < 300; s++) begin
      r   = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      len = $urandom_range(1, 25);
      for (int c = 0; c < len; c++) tick(r, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
